// File: rtl/rgb_matrix_pkg.sv
// Shared types and constants for the 3x4 RGB matrix scanner and its frame store.
package rgb_matrix_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 3;
  localparam logic [2:0] ROW_OFF = 3'b111;

  typedef logic [2:0] pixel_t;
  typedef logic [NUM_ROWS-1:0][2:0] column_t;
  typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0][2:0] frame_t;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [1:0] c);
    return {{(NUM_COLS-1){1'b0}}, 1'b1} << c;
  endfunction

endpackage

// File: rtl/rgb_frame_store.sv
// Double-buffered pixel store: clients write the back buffer, a swap copies it
// whole into the front buffer, and the scanner reads one front column at a time.
module rgb_frame_store
  import rgb_matrix_pkg::*;
(
  input  logic       clock,
  input  logic       n_reset,
  input  logic       wr_en,
  input  logic [1:0] wr_col,
  input  logic [1:0] wr_row,
  input  pixel_t     wr_rgb,
  input  logic       swap,
  input  logic [1:0] rd_col,
  output column_t    rd_data
);

  frame_t back;
  frame_t front;

  // Non-blocking copy means a write on the swap edge lands in back only,
  // while front takes the pre-edge back contents.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      back  <= '0;
      front <= '0;
    end else begin
      if (wr_en && (wr_row < 2'(NUM_ROWS))) begin
        back[wr_col][wr_row] <= wr_rgb;
      end
      if (swap) begin
        front <= back;
      end
    end
  end

  assign rd_data = front[rd_col];

endmodule

// File: rtl/rgb_matrix_scanner.sv
// Column-scanning driver for a 3x4 RGB LED matrix with blanking between columns.
//   state | meaning
//   IDLE  | scan parked, outputs blank, pending swap applied here
//   BLANK | all LEDs off for BLANK_CYCLES before the current column
//   DRIVE | current column lit for DWELL_CYCLES
module rgb_matrix_scanner
  import rgb_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [1:0] wr_col,
  input  logic [1:0] wr_row,
  input  logic [2:0] wr_rgb,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       swap_done,
  output logic       frame_start,
  output logic [2:0] row1,
  output logic [2:0] row2,
  output logic [2:0] row3,
  output logic [3:0] RGB_Column
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  scan_state_t   state;
  scan_state_t   nxt_state;
  logic [1:0]    col;
  logic [1:0]    nxt_col;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic          nxt_fs;
  logic          swap_now;
  column_t       rd_data;

  // Frame boundary: last cycle of column 3 DRIVE, or any cycle parked in IDLE.
  assign swap_now = swap_pending &&
                    ((state == IDLE) ||
                     ((state == DRIVE) && (col == LAST_COL) && (cnt == '0)));

  rgb_frame_store u_store (
    .clock   (clock),
    .n_reset (n_reset),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_row  (wr_row),
    .wr_rgb  (wr_rgb),
    .swap    (swap_now),
    .rd_col  (nxt_col),
    .rd_data (rd_data)
  );

  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_cnt   = cnt;
    nxt_fs    = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_col   = '0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_col   = '0;
          nxt_cnt   = BLANK_LOAD;
          nxt_fs    = 1'b1;
        end
        BLANK: begin
          if (cnt == '0) begin
            nxt_state = DRIVE;
            nxt_cnt   = DWELL_LOAD;
          end else begin
            nxt_cnt = cnt - CW'(1);
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            nxt_state = BLANK;
            nxt_col   = col + 2'd1;
            nxt_cnt   = BLANK_LOAD;
            nxt_fs    = (col == LAST_COL);
          end else begin
            nxt_cnt = cnt - CW'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_col   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Pins are registered from the next-state values so they track the state register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      col          <= '0;
      cnt          <= '0;
      frame_start  <= 1'b0;
      swap_done    <= 1'b0;
      swap_pending <= 1'b0;
      RGB_Column   <= '0;
      row1         <= ROW_OFF;
      row2         <= ROW_OFF;
      row3         <= ROW_OFF;
    end else begin
      state       <= nxt_state;
      col         <= nxt_col;
      cnt         <= nxt_cnt;
      frame_start <= nxt_fs;
      swap_done   <= swap_now;
      if (swap_now) begin
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (nxt_state == DRIVE) begin
        RGB_Column <= col_onehot(nxt_col);
        row1       <= ~rd_data[0];
        row2       <= ~rd_data[1];
        row3       <= ~rd_data[2];
      end else begin
        RGB_Column <= '0;
        row1       <= ROW_OFF;
        row2       <= ROW_OFF;
        row3       <= ROW_OFF;
      end
    end
  end

endmodule
